instruction_sequencer: RTL and testbench
========================================

Name: instruction_sequencer

Overview:
- Decode/sequencing stage directly upstream of the control units.
- Accepts 16-bit AVR opcodes from the fetch stage via a valid/ready handshake.
- Produces a registered 8-bit instruction_id, operand fields and a 2-bit clock_counter that steps through each instruction's execution cycles; downstream control units key their enables (e.g. LPM_enable) on these outputs.
- Multi-cycle instructions hold the handshake off until their last cycle.

Parameters:
- ILLEGAL_ID, 8'hFF, instruction_id emitted for any unrecognised opcode.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- ir_data  input  16  opcode word from fetch.
- ir_valid  input  1  ir_data valid this cycle.
- ir_ready  output  1  sequencer accepts ir_data this cycle (combinational).
- stall  input  1  freeze current instruction (counter and outputs hold).
- flush  input  1  abort current instruction and discard the offered opcode.
- instruction_id  output  8  decoded instruction, registered.
- clock_counter  output  2  execution cycle index, 0-based, registered.
- last_cycle  output  1  current cycle is the final cycle of instruction_id (combinational from registers).
- rd  output  5  destination register field, registered.
- rr  output  5  source register field, registered.
- imm  output  12  immediate/offset field, registered (K for LDI zero-extended, k for RJMP/RCALL).

Behaviour:
- Reset (async, reset_n=0): state IDLE, instruction_id=8'h00, clock_counter=0, rd=rr=0, imm=0. Hence last_cycle=1 and ir_ready=1 once reset releases.
- Decode table (opcode -> id, cycles):
  - 0x0000 NOP -> 00, 1
  - 0000_11rd_dddd_rrrr ADD -> 01, 1
  - 0001_10rd_dddd_rrrr SUB -> 02, 1
  - 0010_11rd_dddd_rrrr MOV -> 03, 1
  - 1110_KKKK_dddd_KKKK LDI -> 04, 1, rd=16+dddd
  - 1100_k12 RJMP -> 10, 2
  - 1101_k12 RCALL -> 11, 3
  - 0x9508 RET -> 12, 4
  - 0x95C8 LPM -> 22, 3, rd=0
  - 1001_000d_dddd_0100 LPM Rd,Z -> 23, 3
  - 1001_000d_dddd_0101 LPM Rd,Z+ -> 24, 3
  - anything else -> ILLEGAL_ID, 1
  - Fields not used by an instruction are 0.
- States:
  - IDLE: no instruction executing; outputs show NOP, counter 0.
  - EXEC: instruction_id valid; clock_counter counts 0..cycles-1.
- last_cycle = (state==IDLE) or (clock_counter == cycles(instruction_id)-1).
- ir_ready = last_cycle and not stall and not flush.
- Accept: ir_valid && ir_ready at edge N -> from edge N, instruction_id/fields = decode(ir_data), clock_counter=0, state EXEC. Zero-bubble back-to-back issue.
- Counting: in EXEC, not last_cycle, no stall/flush -> clock_counter+1 each edge.
- Retire without new opcode: last_cycle, ir_valid=0, no stall -> IDLE, id=00, counter=0, fields 0.
- stall=1: all registers hold, including on last_cycle; no accept.
- flush=1 (priority over stall and ir_valid): next edge -> IDLE, id=00, counter=0, fields 0; offered opcode is not accepted.
- Counter never exceeds cycles-1; a 4-cycle RET uses 0,1,2,3 with no wrap-through.
- Reset asserted mid-instruction: immediate return to reset values; no partial retire.

Test Plan:
- Reset release, ir_valid=0 for 3 cycles -> id=00, counter=0, ir_ready=1, last_cycle=1 throughout.
- Back-to-back LDI 0xE5A3 then ADD 0x0C12, ir_valid held -> id 04 (rd=26, imm=0x53) for one cycle, then 01 (rd=1, rr=2); ir_ready stays 1; counter stays 0.
- LPM 0x95C8 -> id=22, counter 0,1,2; ir_ready=0 on counter 0,1 and 1 on counter 2; next opcode accepted on edge after counter=2.
- RET 0x9508 with stall pulsed while counter=1 for 2 cycles -> counter sequence 0,1,1,1,2,3; id stays 12; no accept while stalled.
- RCALL 0xD00F, flush asserted at counter=1 with ir_valid=1 -> next cycle id=00, counter=0, imm=0; offered opcode not accepted; following valid opcode accepted normally.
- Opcode 0xFFFF -> id=FF, one cycle, last_cycle=1; reset_n pulsed low during an LPM at counter=1 -> outputs return to 00/0 immediately.

Source files
------------

// File: rtl/instruction_sequencer_if.sv
// Fetch-to-sequencer opcode handshake: fetch offers ir_data with ir_valid,
// the sequencer answers with a combinational ir_ready.
interface instruction_sequencer_if;
    logic [15:0] ir_data;
    logic        ir_valid;
    logic        ir_ready;

    modport master (output ir_data, output ir_valid, input ir_ready);
    modport slave  (input ir_data, input ir_valid, output ir_ready);
endinterface

// File: rtl/instruction_sequencer.sv
// AVR decode/sequencing stage. Decodes 16-bit opcodes into an instruction id
// plus operand fields and steps a 2-bit clock_counter through each
// instruction's execution cycles. Multi-cycle instructions hold ir_ready low
// until their final cycle so the next opcode issues with no bubble.
module instruction_sequencer #(
    parameter logic [7:0] ILLEGAL_ID = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset_n,
    instruction_sequencer_if.slave          ir,
    input  logic                            stall,
    input  logic                            flush,
    output logic [7:0]                      instruction_id,
    output logic [1:0]                      clock_counter,
    output logic                            last_cycle,
    output logic [4:0]                      rd,
    output logic [4:0]                      rr,
    output logic [11:0]                     imm
);

    typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [4:0]  rd;
        logic [4:0]  rr;
        logic [11:0] imm;
    } dec_t;

    // Opcode -> id and operand fields; unused fields stay zero.
    function automatic dec_t decode(input logic [15:0] op);
        dec_t d;
        d = '0;
        if (op == 16'h0000) begin
            d.id = 8'h00;
        end else if (op[15:10] == 6'b000011) begin
            d.id = 8'h01;
            d.rd = {op[8], op[7:4]};
            d.rr = {op[9], op[3:0]};
        end else if (op[15:10] == 6'b000110) begin
            d.id = 8'h02;
            d.rd = {op[8], op[7:4]};
            d.rr = {op[9], op[3:0]};
        end else if (op[15:10] == 6'b001011) begin
            d.id = 8'h03;
            d.rd = {op[8], op[7:4]};
            d.rr = {op[9], op[3:0]};
        end else if (op[15:12] == 4'b1110) begin
            // LDI only reaches the upper register bank r16..r31
            d.id  = 8'h04;
            d.rd  = {1'b1, op[7:4]};
            d.imm = {4'b0000, op[11:8], op[3:0]};
        end else if (op[15:12] == 4'b1100) begin
            d.id  = 8'h10;
            d.imm = op[11:0];
        end else if (op[15:12] == 4'b1101) begin
            d.id  = 8'h11;
            d.imm = op[11:0];
        end else if (op == 16'h9508) begin
            d.id = 8'h12;
        end else if (op == 16'h95C8) begin
            d.id = 8'h22;
        end else if ((op[15:9] == 7'b1001000) && (op[3:0] == 4'b0100)) begin
            d.id = 8'h23;
            d.rd = op[8:4];
        end else if ((op[15:9] == 7'b1001000) && (op[3:0] == 4'b0101)) begin
            d.id = 8'h24;
            d.rd = op[8:4];
        end else begin
            d.id = ILLEGAL_ID;
        end
        return d;
    endfunction

    // Index of the final execution cycle for a decoded id (cycles - 1).
    function automatic logic [1:0] last_index(input logic [7:0] id);
        logic [1:0] n;
        case (id)
            8'h10:   n = 2'd1;
            8'h11:   n = 2'd2;
            8'h12:   n = 2'd3;
            8'h22:   n = 2'd2;
            8'h23:   n = 2'd2;
            8'h24:   n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    state_t     state_r;
    logic [7:0] id_r;
    logic [1:0] cnt_r;
    logic [4:0] rd_r;
    logic [4:0] rr_r;
    logic [11:0] imm_r;
    logic       last_s;
    logic       ready_s;
    dec_t       dec_s;

    // Final-cycle detection and handshake readiness from registered state.
    always_comb begin
        last_s  = 1'b0;
        ready_s = 1'b0;
        dec_s   = decode(ir.ir_data);
        if (state_r == IDLE) begin
            last_s = 1'b1;
        end else begin
            last_s = (cnt_r == last_index(id_r));
        end
        ready_s = last_s && !stall && !flush;
    end

    // Sequencer FSM: flush beats stall beats accept/retire/count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            id_r    <= 8'h00;
            cnt_r   <= 2'd0;
            rd_r    <= 5'd0;
            rr_r    <= 5'd0;
            imm_r   <= 12'd0;
        end else if (flush) begin
            state_r <= IDLE;
            id_r    <= 8'h00;
            cnt_r   <= 2'd0;
            rd_r    <= 5'd0;
            rr_r    <= 5'd0;
            imm_r   <= 12'd0;
        end else if (stall) begin
            state_r <= state_r;
        end else if (last_s) begin
            if (ir.ir_valid) begin
                state_r <= EXEC;
                id_r    <= dec_s.id;
                cnt_r   <= 2'd0;
                rd_r    <= dec_s.rd;
                rr_r    <= dec_s.rr;
                imm_r   <= dec_s.imm;
            end else begin
                state_r <= IDLE;
                id_r    <= 8'h00;
                cnt_r   <= 2'd0;
                rd_r    <= 5'd0;
                rr_r    <= 5'd0;
                imm_r   <= 12'd0;
            end
        end else begin
            cnt_r <= cnt_r + 2'd1;
        end
    end

    assign ir.ir_ready     = ready_s;
    assign last_cycle      = last_s;
    assign instruction_id  = id_r;
    assign clock_counter   = cnt_r;
    assign rd              = rd_r;
    assign rr              = rr_r;
    assign imm             = imm_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: directed test-plan sequences with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural
// model built from the opcode table and the issue/stall/flush rules.
module tb_instruction_sequencer;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [7:0]  instruction_id;
    logic [1:0]  clock_counter;
    logic        last_cycle;
    logic [4:0]  rd;
    logic [4:0]  rr;
    logic [11:0] imm;

    int checks;
    int errors;

    instruction_sequencer_if bus ();

    instruction_sequencer #(.ILLEGAL_ID(8'hFF)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ir             (bus),
        .stall          (stall),
        .flush          (flush),
        .instruction_id (instruction_id),
        .clock_counter  (clock_counter),
        .last_cycle     (last_cycle),
        .rd             (rd),
        .rr             (rr),
        .imm            (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Pattern table: opcode matches when (op & mask) == match.
    typedef struct {
        logic [15:0] mask;
        logic [15:0] match;
        logic [7:0]  id;
        int          cycles;
    } pat_t;

    pat_t table_q[$];

    logic [7:0]  m_id;
    int          m_cnt;
    int          m_cycles;   // 0 while idle
    logic [4:0]  m_rd;
    logic [4:0]  m_rr;
    logic [11:0] m_imm;

    function automatic void model_clear();
        m_id = 8'h00; m_cnt = 0; m_cycles = 0;
        m_rd = 5'd0; m_rr = 5'd0; m_imm = 12'd0;
    endfunction

    function automatic void model_load(input logic [15:0] op);
        int hit;
        hit = -1;
        foreach (table_q[i]) begin
            if (hit < 0 && ((op & table_q[i].mask) == table_q[i].match)) hit = i;
        end
        m_rd = 5'd0; m_rr = 5'd0; m_imm = 12'd0; m_cnt = 0;
        if (hit < 0) begin
            m_id = 8'hFF; m_cycles = 1;
        end else begin
            m_id = table_q[hit].id; m_cycles = table_q[hit].cycles;
        end
        // operand extraction by instruction class, straight from AVR encodings
        if (m_id == 8'h01 || m_id == 8'h02 || m_id == 8'h03) begin
            m_rd = 5'((op >> 4) & 16'h000F) + 5'((op >> 8) & 16'h0001) * 5'd16;
            m_rr = 5'(op & 16'h000F) + 5'((op >> 9) & 16'h0001) * 5'd16;
        end else if (m_id == 8'h04) begin
            m_rd  = 5'd16 + 5'((op >> 4) & 16'h000F);
            m_imm = 12'(((op >> 8) & 16'h000F) * 16 + (op & 16'h000F));
        end else if (m_id == 8'h10 || m_id == 8'h11) begin
            m_imm = 12'(op % 4096);
        end else if (m_id == 8'h23 || m_id == 8'h24) begin
            m_rd = 5'((op >> 4) & 16'h001F);
        end else begin
            m_rd = 5'd0;
        end
    endfunction

    function automatic logic model_last();
        return (m_cycles == 0) || (m_cnt == m_cycles - 1);
    endfunction

    // Per-cycle compare at negedge, model advance at posedge.
    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            if (!reset_n) model_clear();
            checks++;
            if (instruction_id !== m_id || clock_counter !== 2'(m_cnt) ||
                rd !== m_rd || rr !== m_rr || imm !== m_imm ||
                last_cycle !== model_last() ||
                bus.ir_ready !== (model_last() && !stall && !flush)) begin
                errors++;
                $display("FAIL cycle_model t=%0t got id=%h cnt=%0d rd=%0d rr=%0d imm=%h last=%b rdy=%b expected id=%h cnt=%0d rd=%0d rr=%0d imm=%h last=%b rdy=%b",
                         $time, instruction_id, clock_counter, rd, rr, imm, last_cycle, bus.ir_ready,
                         m_id, m_cnt, m_rd, m_rr, m_imm, model_last(), model_last() && !stall && !flush);
            end
            @(posedge clk);
            if (!reset_n)                 model_clear();
            else if (flush)               model_clear();
            else if (stall)               m_cnt = m_cnt;
            else if (model_last()) begin
                if (bus.ir_valid)         model_load(bus.ir_data);
                else                      model_clear();
            end else                      m_cnt = m_cnt + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Apply inputs, then return 1 time unit after the next rising edge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic s, input logic f);
        bus.ir_valid = v; bus.ir_data = d; stall = s; flush = f;
        @(posedge clk); #1;
    endtask

    task automatic lit(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp_v);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        table_q.push_back('{16'hFFFF, 16'h0000, 8'h00, 1});
        table_q.push_back('{16'hFC00, 16'h0C00, 8'h01, 1});
        table_q.push_back('{16'hFC00, 16'h1800, 8'h02, 1});
        table_q.push_back('{16'hFC00, 16'h2C00, 8'h03, 1});
        table_q.push_back('{16'hF000, 16'hE000, 8'h04, 1});
        table_q.push_back('{16'hF000, 16'hC000, 8'h10, 2});
        table_q.push_back('{16'hF000, 16'hD000, 8'h11, 3});
        table_q.push_back('{16'hFFFF, 16'h9508, 8'h12, 4});
        table_q.push_back('{16'hFFFF, 16'h95C8, 8'h22, 3});
        table_q.push_back('{16'hFE0F, 16'h9004, 8'h23, 3});
        table_q.push_back('{16'hFE0F, 16'h9005, 8'h24, 3});

        reset_n = 1'b0;
        bus.ir_valid = 1'b0; bus.ir_data = 16'h0000; stall = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'h0000, 1'b0, 1'b0);
            lit("idle_id", instruction_id, 8'h00);
            lit("idle_cnt", clock_counter, 0);
            lit("idle_last", last_cycle, 1);
            lit("idle_ready", bus.ir_ready, 1);
        end

        // back-to-back LDI then ADD
        cyc(1'b1, 16'hE5A3, 1'b0, 1'b0);
        lit("ldi_id", instruction_id, 8'h04);
        lit("ldi_rd", rd, 26);
        lit("ldi_imm", imm, 12'h053);
        cyc(1'b1, 16'h0C12, 1'b0, 1'b0);
        lit("add_id", instruction_id, 8'h01);
        lit("add_rd", rd, 1);
        lit("add_rr", rr, 2);
        lit("add_cnt", clock_counter, 0);

        // LPM three cycles, NOP queued behind it
        cyc(1'b1, 16'h95C8, 1'b0, 1'b0);
        lit("lpm_id", instruction_id, 8'h22);
        lit("lpm_c0_ready", bus.ir_ready, 0);
        cyc(1'b1, 16'h0000, 1'b0, 1'b0);
        lit("lpm_cnt1", clock_counter, 1);
        cyc(1'b1, 16'h0000, 1'b0, 1'b0);
        lit("lpm_cnt2", clock_counter, 2);
        lit("lpm_c2_ready", bus.ir_ready, 1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        lit("lpm_next_cnt", clock_counter, 0);
        lit("lpm_next_id", instruction_id, 8'h00);

        // RET with stall at counter 1
        cyc(1'b1, 16'h9508, 1'b0, 1'b0);
        lit("ret_id", instruction_id, 8'h12);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        lit("ret_cnt1", clock_counter, 1);
        cyc(1'b1, 16'h0C12, 1'b1, 1'b0);
        lit("ret_stall_a", clock_counter, 1);
        cyc(1'b1, 16'h0C12, 1'b1, 1'b0);
        lit("ret_stall_b", clock_counter, 1);
        lit("ret_stall_id", instruction_id, 8'h12);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        lit("ret_cnt2", clock_counter, 2);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        lit("ret_cnt3", clock_counter, 3);
        lit("ret_last", last_cycle, 1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);

        // RCALL flushed at counter 1, then SUB accepted normally
        cyc(1'b1, 16'hD00F, 1'b0, 1'b0);
        lit("rcall_imm", imm, 12'h00F);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 16'h0C12, 1'b0, 1'b1);
        lit("flush_id", instruction_id, 8'h00);
        lit("flush_imm", imm, 0);
        cyc(1'b1, 16'h1812, 1'b0, 1'b0);
        lit("post_flush_id", instruction_id, 8'h02);

        // illegal opcode, then reset during LPM
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
        lit("illegal_id", instruction_id, 8'hFF);
        lit("illegal_last", last_cycle, 1);
        cyc(1'b1, 16'h95C8, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        lit("lpm_rst_pre", clock_counter, 1);
        #2 reset_n = 1'b0;
        #1;
        lit("rst_mid_id", instruction_id, 8'h00);
        lit("rst_mid_cnt", clock_counter, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] op;
            case ($urandom_range(0, 11))
                0:  op = 16'h0000;
                1:  op = 16'h0C00 | 16'($urandom_range(0, 1023));
                2:  op = 16'h1800 | 16'($urandom_range(0, 1023));
                3:  op = 16'h2C00 | 16'($urandom_range(0, 1023));
                4:  op = 16'hE000 | 16'($urandom_range(0, 4095));
                5:  op = 16'hC000 | 16'($urandom_range(0, 4095));
                6:  op = 16'hD000 | 16'($urandom_range(0, 4095));
                7:  op = 16'h9508;
                8:  op = 16'h95C8;
                9:  op = 16'h9004 | (16'($urandom_range(0, 31)) << 4) | 16'($urandom_range(0, 1));
                default: op = 16'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            cyc($urandom_range(0, 9) < 7, op, $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 5);
        end
        reset_n = 1'b1;
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
